demux_4_buf: RTL

Four-way buffered demultiplexer, the write-side counterpart of the 4-input selector `mux_4`. It accepts one WIDTH-bit word per cycle, tagged with a 2-bit destination. It routes the word into one of four independent per-channel FIFOs. Each channel drains through its own valid/ready handshake. It sits between a single producer (e.g. a writeback or result bus) and four consumers that may stall independently.

---
 rtl/demux_4_buf.sv | 105 ++++++++++
 1 files changed

// File: rtl/demux_4_buf.sv
// Four-way buffered demultiplexer: routes each tagged input word into one of
// four independent FIFOs, each drained through its own valid/ready handshake.
module demux_4_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [1:0]               in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data_a,
  output logic [WIDTH-1:0]         out_data_b,
  output logic [WIDTH-1:0]         out_data_c,
  output logic [WIDTH-1:0]         out_data_d,
  output logic                     out_valid_a,
  output logic                     out_valid_b,
  output logic                     out_valid_c,
  output logic                     out_valid_d,
  input  logic                     out_ready_a,
  input  logic                     out_ready_b,
  input  logic                     out_ready_c,
  input  logic                     out_ready_d,
  output logic [$clog2(DEPTH):0]   count_a,
  output logic [$clog2(DEPTH):0]   count_b,
  output logic [$clog2(DEPTH):0]   count_c,
  output logic [$clog2(DEPTH):0]   count_d,
  output logic                     busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_r    [4][DEPTH];
  logic [PW-1:0]    wr_ptr_r [4];
  logic [PW-1:0]    rd_ptr_r [4];
  logic [CW-1:0]    count_r  [4];
  logic [WIDTH-1:0] head_s   [4];
  logic [3:0]       out_ready_s;
  logic [3:0]       push_s;
  logic [3:0]       pop_s;
  logic [3:0]       valid_s;

  assign out_ready_s = {out_ready_d, out_ready_c, out_ready_b, out_ready_a};

  // Full is judged on count alone, so a full channel never takes a push even while popping.
  assign in_ready = (count_r[in_sel] != CW'(DEPTH));

  for (genvar ch = 0; ch < 4; ch++) begin : g_ch
    assign valid_s[ch] = (count_r[ch] != {CW{1'b0}});
    assign push_s[ch]  = in_valid && in_ready && (in_sel == 2'(ch));
    assign pop_s[ch]   = valid_s[ch] && out_ready_s[ch];
    assign head_s[ch]  = valid_s[ch] ? mem_r[ch][rd_ptr_r[ch]] : {WIDTH{1'b0}};
  end

  // Pointer and occupancy bookkeeping for all four channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        wr_ptr_r[k] <= {PW{1'b0}};
        rd_ptr_r[k] <= {PW{1'b0}};
        count_r[k]  <= {CW{1'b0}};
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (push_s[k]) begin
          wr_ptr_r[k] <= wr_ptr_r[k] + PW'(1);
        end
        if (pop_s[k]) begin
          rd_ptr_r[k] <= rd_ptr_r[k] + PW'(1);
        end
        case ({push_s[k], pop_s[k]})
          2'b10:   count_r[k] <= count_r[k] + CW'(1);
          2'b01:   count_r[k] <= count_r[k] - CW'(1);
          default: count_r[k] <= count_r[k];
        endcase
      end
    end
  end

  // Word storage; contents are don't-care until counted valid, so no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (push_s[k]) begin
        mem_r[k][wr_ptr_r[k]] <= in_data;
      end
    end
  end

  assign out_data_a  = head_s[0];
  assign out_data_b  = head_s[1];
  assign out_data_c  = head_s[2];
  assign out_data_d  = head_s[3];
  assign out_valid_a = valid_s[0];
  assign out_valid_b = valid_s[1];
  assign out_valid_c = valid_s[2];
  assign out_valid_d = valid_s[3];
  assign count_a     = count_r[0];
  assign count_b     = count_r[1];
  assign count_c     = count_r[2];
  assign count_d     = count_r[3];
  assign busy        = |valid_s;

endmodule
